// File: rtl/usb_rx_bit_timer_pkg.sv
// Shared types and default timing constants for the USB full-speed RX path.
// Used by the bit timer, RX shift register and RX control FSM.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    RUN
  } rx_timer_state_t;

  localparam int CLKS_PER_BIT_DEF = 8;
  localparam int SAMPLE_PHASE_DEF = 3;
  localparam int MAX_NOEDGE_DEF   = 7;

endpackage

// File: rtl/usb_rx_bit_timer_phase_counter.sv
// Bit-phase counter: loadable, wraps at CLKS_PER_BIT-1.
// Load has priority over the count enable.
module rx_phase_counter #(
  parameter int  CLKS_PER_BIT = 8,
  localparam int PHASE_W      = $clog2(CLKS_PER_BIT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_val,
  input  logic               en,
  output logic [PHASE_W-1:0] phase
);

  localparam logic [PHASE_W-1:0] LAST =
    PHASE_W'(CLKS_PER_BIT - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if (load) begin
      phase <= load_val;
    end else if (en) begin
      if (phase == LAST) begin
        phase <= '0;
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_rx_bit_timer.sv
// RX bit timer: NRZI edge phase recovery, mid-bit sample strobe,
// data-bit counting with stuffed-bit skip and loss-of-sync detection.
module usb_rx_bit_timer
  import usb_rx_pkg::*;
#(
  parameter int  CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int  SAMPLE_PHASE = SAMPLE_PHASE_DEF,
  parameter int  MAX_NOEDGE   = MAX_NOEDGE_DEF,
  localparam int PHASE_W      = $clog2(CLKS_PER_BIT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               clear,
  input  logic               d_edge,
  input  logic               stuff_bit,
  output logic               rx_sample,
  output logic [2:0]         bit_count,
  output logic               byte_done,
  output logic               sync_err,
  output logic [PHASE_W-1:0] bit_phase
);

  localparam int NE_RAW = $clog2(MAX_NOEDGE + 1);
  localparam int NE_W   = (NE_RAW < 3) ? 3 : NE_RAW;
  localparam logic [NE_W-1:0] NE_LAST =
    NE_W'(MAX_NOEDGE - 1);
  localparam logic [PHASE_W-1:0] SMP =
    PHASE_W'(SAMPLE_PHASE);

  rx_timer_state_t    state;
  rx_timer_state_t    state_nxt;
  logic [NE_W-1:0]    noedge;
  logic               lost;
  logic               flush;
  logic               err_set;
  logic               ph_load;
  logic [PHASE_W-1:0] ph_val;
  logic               ph_en;

  assign rx_sample = (state == RUN) && (bit_phase == SMP);
  assign lost      = rx_sample && (noedge == NE_LAST) && !d_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    flush     = 1'b0;
    err_set   = 1'b0;
    ph_load   = 1'b0;
    ph_val    = '0;
    ph_en     = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      flush     = 1'b1;
    end else if (clear) begin
      state_nxt = SYNC;
      flush     = 1'b1;
    end else if (lost) begin
      state_nxt = SYNC;
      flush     = 1'b1;
      err_set   = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = SYNC;
          ph_load   = 1'b1;
        end
        SYNC: begin
          ph_load = 1'b1;
          if (d_edge) begin
            state_nxt = RUN;
            ph_val    = PHASE_W'(1);
          end
        end
        RUN: begin
          if (d_edge) begin
            ph_load = 1'b1;
            ph_val  = PHASE_W'(1);
          end else begin
            ph_en = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          ph_load   = 1'b1;
        end
      endcase
    end
    if (flush) begin
      ph_load = 1'b1;
      ph_val  = '0;
    end
  end

  rx_phase_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_phase (
    .clk     (clk),
    .rst     (rst),
    .load    (ph_load),
    .load_val(ph_val),
    .en      (ph_en),
    .phase   (bit_phase)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_count <= '0;
      noedge    <= '0;
      byte_done <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      sync_err  <= err_set;
      if (flush) begin
        bit_count <= '0;
        noedge    <= '0;
      end else begin
        if (rx_sample && !stuff_bit) begin
          bit_count <= bit_count + 3'd1;
          byte_done <= (bit_count == 3'd7);
        end
        if (d_edge) begin
          noedge <= '0;
        end else if (rx_sample) begin
          noedge <= noedge + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_bit_timer.sv
// Scoreboard bench for usb_rx_bit_timer: stimulus queues expected
// output events, a negedge monitor pops and compares them.
module tb_usb_rx_bit_timer;

  localparam logic [2:0] K_SMP = 3'b100;
  localparam logic [2:0] K_BD  = 3'b010;
  localparam logic [2:0] K_SE  = 3'b001;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
    logic [2:0] bc;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       clear;
  logic       d_edge;
  logic       stuff_bit;
  logic       rx_sample;
  logic [2:0] bit_count;
  logic       byte_done;
  logic       sync_err;
  logic [2:0] bit_phase;

  int   cyc;
  int   checks;
  int   errors;
  ev_t  q[$];
  ev_t  m_e;
  logic [2:0] m_got;

  usb_rx_bit_timer dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .clear    (clear),
    .d_edge   (d_edge),
    .stuff_bit(stuff_bit),
    .rx_sample(rx_sample),
    .bit_count(bit_count),
    .byte_done(byte_done),
    .sync_err (sync_err),
    .bit_phase(bit_phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_sample || byte_done || sync_err) begin
      m_got = {rx_sample, byte_done, sync_err};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out cyc=%0d got=%b want=none",
                 cyc, m_got);
      end else begin
        m_e = q.pop_front();
        if (m_e.cyc != cyc || m_e.kind != m_got ||
            m_e.bc != bit_count) begin
          errors++;
          $display("FAIL event cyc=%0d kind=%b bc=%0d want cyc=%0d kind=%b bc=%0d",
                   cyc, m_got, bit_count, m_e.cyc, m_e.kind, m_e.bc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic resync();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("clear_phase", 8'(bit_phase), 8'd0);
    chk("clear_count", 8'(bit_count), 8'd0);
  endtask

  // n bits, edge gaps alternating ga/gb, stuffed bit at sample sk
  task automatic run(input int n, input int ga, input int gb,
                     input int sk);
    int cnt;
    int e;
    int g;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      e = cyc;
      g = (i == n - 1) ? 4 : ((i % 2 == 0) ? ga : gb);
      q.push_back(ev_t'{e + 3, K_SMP, 3'(cnt)});
      if (i != sk) begin
        if (cnt == 7) q.push_back(ev_t'{e + 4, K_BD, 3'd0});
        cnt = (cnt + 1) % 8;
      end
      for (int j = 0; j < g; j++) begin
        d_edge    = (j == 0);
        stuff_bit = (j == 3 && i == sk) || (j == 5);
        tick(1);
      end
    end
    d_edge    = 1'b0;
    stuff_bit = 1'b0;
  endtask

  initial begin
    int t;
    cyc       = 0;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    enable    = 1'b0;
    clear     = 1'b0;
    d_edge    = 1'b0;
    stuff_bit = 1'b0;
    tick(3);
    chk("rst_phase", 8'(bit_phase), 8'd0);
    chk("rst_count", 8'(bit_count), 8'd0);
    chk("rst_outs", 8'({rx_sample, byte_done, sync_err}), 8'd0);
    rst    = 1'b0;
    enable = 1'b1;
    tick(50);
    chk("sync_idle_phase", 8'(bit_phase), 8'd0);
    chk("sync_idle_count", 8'(bit_count), 8'd0);

    resync();
    run(9, 8, 8, -1);

    resync();
    run(10, 8, 8, 2);

    resync();
    run(9, 7, 9, -1);

    resync();
    t = cyc;
    for (int k = 0; k < 7; k++)
      q.push_back(ev_t'{t + 3 + 8 * k, K_SMP, 3'(k)});
    q.push_back(ev_t'{t + 52, K_SE, 3'd0});
    d_edge = 1'b1;
    tick(1);
    d_edge = 1'b0;
    chk("phase_after_sync", 8'(bit_phase), 8'd1);
    tick(60);
    chk("lost_phase", 8'(bit_phase), 8'd0);
    chk("lost_count", 8'(bit_count), 8'd0);

    resync();
    run(5, 8, 8, -1);
    chk("midbyte_count", 8'(bit_count), 8'd5);
    enable = 1'b0;
    tick(1);
    chk("abort_count", 8'(bit_count), 8'd0);
    chk("abort_phase", 8'(bit_phase), 8'd0);
    enable = 1'b1;
    tick(1);
    clear  = 1'b1;
    d_edge = 1'b1;
    tick(1);
    clear  = 1'b0;
    d_edge = 1'b0;
    chk("clear_wins_phase", 8'(bit_phase), 8'd0);
    tick(12);
    chk("clear_wins_hold", 8'(bit_phase), 8'd0);

    tick(5);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got=%0d left want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
